// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: operand forwarding select, long-latency busy tracking and decode stall.
// Optional stall-cycle perf counter enabled by defining HAZARD_PERF_CNT_EN.

module hazard_fwd_cmp (
  input  logic       regwrite,
  input  logic [4:0] rd,
  input  logic [4:0] rs,
  output logic       hit
);
  assign hit = regwrite && (rd == rs) && (rs != 5'd0);
endmodule

module hazard_scoreboard #(
  parameter int NUM_FWD_STAGES  = 3,
  parameter int MAX_OUTSTANDING = 4,
  localparam int FW = $clog2(NUM_FWD_STAGES+1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [4:0]                  rs1_d,
  input  logic [4:0]                  rs2_d,
  input  logic [4:0]                  rd_d,
  input  logic                        longlat_d,
  input  logic [4:0]                  rs1_e,
  input  logic [4:0]                  rs2_e,
  input  logic [NUM_FWD_STAGES-1:0]   regwrite_s,
  input  logic [5*NUM_FWD_STAGES-1:0] rd_s,
  input  logic                        issue_valid,
  input  logic [4:0]                  issue_rd,
  input  logic                        done_valid,
  input  logic [4:0]                  done_rd,
  input  logic                        flush,
  output logic [FW-1:0]               fwda_e,
  output logic [FW-1:0]               fwdb_e,
  output logic                        stall_d,
  output logic                        full,
  output logic [31:0]                 pending
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [31:0]                stall_cycles
`endif
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } ll_evt_t;

  ll_evt_t issue_ev, done_ev;
  assign issue_ev = '{vld: issue_valid, rd: issue_rd};
  assign done_ev  = '{vld: done_valid,  rd: done_rd};

  logic [NUM_FWD_STAGES-1:0][4:0] rd_stage;
  logic [NUM_FWD_STAGES-1:0]      hit_a, hit_b;
  assign rd_stage = rd_s;

  for (genvar k = 0; k < NUM_FWD_STAGES; k++) begin : g_stage
    hazard_fwd_cmp u_cmp_a (.regwrite(regwrite_s[k]), .rd(rd_stage[k]), .rs(rs1_e), .hit(hit_a[k]));
    hazard_fwd_cmp u_cmp_b (.regwrite(regwrite_s[k]), .rd(rd_stage[k]), .rs(rs2_e), .hit(hit_b[k]));
  end

  // Walk oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwda_e = '0;
    fwdb_e = '0;
    for (int k = NUM_FWD_STAGES-1; k >= 0; k--) begin
      if (hit_a[k]) fwda_e = FW'(k+1);
      if (hit_b[k]) fwdb_e = FW'(k+1);
    end
  end

  logic [31:0] pend_q, pend_nxt;
  logic [3:0]  cnt_q;
  logic        inc, dec;

  assign inc = issue_ev.vld & ~done_ev.vld;
  assign dec = done_ev.vld & ~issue_ev.vld;

  // Issue is applied after done so a same-register collision leaves the bit set.
  always_comb begin
    pend_nxt = pend_q;
    if (done_ev.vld)  pend_nxt[done_ev.rd]  = 1'b0;
    if (issue_ev.vld) pend_nxt[issue_ev.rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_nxt;
      if (inc && !full)               cnt_q <= cnt_q + 4'd1;
      else if (dec && cnt_q != 4'd0)  cnt_q <= cnt_q - 4'd1;
    end
  end

  assign pending = pend_q;
  assign full    = (cnt_q == 4'(MAX_OUTSTANDING));
  assign stall_d = ~flush & (pend_q[rs1_d] | pend_q[rs2_d] | pend_q[rd_d] | (longlat_d & full));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(inc && full))
    else $error("hazard_scoreboard: issue while full");
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(dec && cnt_q == 4'd0))
    else $error("hazard_scoreboard: done with nothing outstanding");

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall_cycles <= '0;
    else if (stall_d && stall_cycles != '1)   stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter NUM_FWD_STAGES, default 3, meaning the number of post-execute stages eligible for forwarding (legal 1..4); FW = $clog2(NUM_FWD_STAGES+1).
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of in-flight long-latency ops (legal 1..8).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port rs1_d / rs2_d / rd_d, input, 5 bits each, the decode-stage source and destination registers.
REQ-006 The block SHALL have port longlat_d, input, 1 bit, meaning the decode op is long-latency (divide or uncached load).
REQ-007 The block SHALL have port rs1_e / rs2_e, input, 5 bits each, the execute-stage sources.
REQ-008 The block SHALL have port regwrite_s, input, NUM_FWD_STAGES bits, meaning stage k writes rd; bit 0 is the youngest stage.
REQ-009 The block SHALL have port rd_s, input, 5*NUM_FWD_STAGES bits, the stage k destination in bits [5k+4:5k].
REQ-010 The block SHALL have port issue_valid / issue_rd, input, 1 bit + 5 bits, meaning a long-latency op leaves execute.
REQ-011 The block SHALL have port done_valid / done_rd, input, 1 bit + 5 bits, meaning a long-latency result is written back.
REQ-012 The block SHALL have port flush, input, 1 bit, the pipeline flush request.
REQ-013 The block SHALL have port fwda_e / fwdb_e, output, FW bits each, the operand source: 0 = register file, k+1 = stage k.
REQ-014 The block SHALL have port stall_d, output, 1 bit, the decode/fetch hold.
REQ-015 The block SHALL have port full, output, 1 bit, meaning the outstanding count equals MAX_OUTSTANDING.
REQ-016 The block SHALL have port pending, output, 32 bits, the per-register busy bitmap.

Function
REQ-017 The block SHALL drive fwda_e as k+1 for the lowest k with regwrite_s[k] set, rd_s[k] equal to rs1_e and rs1_e nonzero, and as 0 otherwise; fwdb_e SHALL do the same for rs2_e; both are combinational.
REQ-018 The block SHALL set pending[issue_rd] on the clock edge where issue_valid is high and issue_rd is nonzero.
REQ-019 The block SHALL clear pending[done_rd] on the clock edge where done_valid is high.
REQ-020 When issue and done target the same register in the same cycle, the block SHALL leave the pending bit set.
REQ-021 The block SHALL never set pending[0]; pending[0] reads 0.
REQ-022 The block SHALL hold the outstanding count in a 4-bit counter: +1 on issue only, -1 on done only, unchanged on both or neither.
REQ-023 An issue while full, or a done while the count is 0, SHALL leave the count unchanged (no wrap), and in simulation the block SHALL report an assertion error.
REQ-024 The block SHALL assert stall_d combinationally when any of these holds: pending[rs1_d] is set; pending[rs2_d] is set; pending[rd_d] is set (WAW); or longlat_d and full are both high.
REQ-025 The block SHALL force stall_d low while flush is high.
REQ-026 Flush SHALL NOT alter the pending bits or the count, because issued long-latency ops always complete.
REQ-027 Stall latency: stall_d SHALL deassert in the cycle after the done edge that clears the last blocking bit.

Reset
REQ-028 While rst_n is low, the block SHALL clear pending to 0 and the count to 0; full, stall_d, fwda_e and fwdb_e then read 0 given zero inputs.
REQ-029 A reset asserted mid-operation SHALL discard all outstanding tracking immediately, without waiting for a clock edge.

Configuration
REQ-030 When macro HAZARD_PERF_CNT_EN is defined, the block SHALL add a 32-bit output stall_cycles that counts the cycles in which stall_d is high, saturates at 0xFFFFFFFF and resets to 0.
REQ-031 When HAZARD_PERF_CNT_EN is undefined, the block SHALL have neither the stall_cycles port nor its counter, and all other behaviour SHALL be identical.

Verification
REQ-032 Bench scenario, forwarding priority: NUM_FWD_STAGES=3, rs1_e=5, regwrite_s=3'b110, rd_s={5,5,x} -> fwda_e=2; with rs1_e=0 under the same stage state -> fwda_e=0.
REQ-033 Bench scenario, RAW stall: issue rd=7; next cycle rs2_d=7 -> stall_d=1 until done rd=7, then 0 on the following cycle; pending[7] goes 1 then 0.
REQ-034 Bench scenario, fill to full: 4 issues to x1..x4 -> full=1; longlat_d=1 -> stall_d=1; one done -> full=0 and stall_d=0.
REQ-035 Bench scenario, simultaneous issue and done on rd=9 -> pending[9] stays 1 and the count is unchanged.
REQ-036 Bench scenario, flush during stall -> stall_d=0 while flush is high and pending is unchanged; rst_n low mid-stream -> pending=0 and count=0 asynchronously.
REQ-037 Bench scenario, with HAZARD_PERF_CNT_EN: 10 stalled cycles -> stall_cycles=10; with the counter preloaded by force to 0xFFFFFFFF plus one stall cycle -> it stays 0xFFFFFFFF.
